// File: rtl/jk_drive_sequencer.sv
// Command sequencer that drives J/K inputs of a downstream JK flip-flop array,
// tracks the expected flop state in a shadow register and flags read-back mismatches.
module jk_drive_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [3:0]       cmd_count,
    input  logic             clr_err,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both 1; cmd_ready is high only in IDLE, and cmd_valid at any other time is ignored.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] exp_q;
    logic             err_q;
    logic             accept;
    logic             mismatch;
    logic [WIDTH-1:0] exp_nxt;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        j         = '0;
        k         = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                // Op encoding maps directly: bit 1 drives J, bit 0 drives K.
                j = op_q[1] ? mask_q : '0;
                k = op_q[0] ? mask_q : '0;
                if (cnt_q == 4'd0) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Characteristic JK equation; unselected bits see j=k=0 and therefore hold.
    assign exp_nxt  = (j & ~exp_q) | (~k & exp_q);
    assign mismatch = (state == CHECK) && (q_fb != exp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= 2'd0;
            mask_q <= '0;
            cnt_q  <= 4'd0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                mask_q <= cmd_mask;
                cnt_q  <= cmd_count;
            end
            if (state == DRIVE) begin
                exp_q <= exp_nxt;
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            // A fresh mismatch takes priority over a simultaneous clear.
            if (mismatch) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Randomized bench for jk_drive_sequencer with a downstream JK array model,
// a command-level reference model and a queue-based scoreboard.
module tb_jk_drive_sequencer;

    localparam int W = 4;
    localparam logic [1:0] OP_HOLD   = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_SET    = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         clr_err = 1'b0;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_mask = '0;
    logic [3:0]   cmd_count = 4'd0;
    logic [W-1:0] q_fb;
    logic         cmd_ready, busy, done, err;
    logic [W-1:0] j, k;
    logic [1:0]   state_dbg;

    logic [W-1:0] ff_q;
    logic [W-1:0] inj_val = '0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] mask;
        int           count;
        logic [W-1:0] exp_v;
        logic         err_exp;
        int           acc_cyc;
    } item_t;

    item_t        exp_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           last_acc = 0;
    logic [W-1:0] ref_v = '0;
    logic         err_model = 1'b0;

    jk_drive_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .clr_err   (clr_err),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / downstream array ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_q <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                case ({j[b], k[b]})
                    2'b01:   ff_q[b] <= 1'b0;
                    2'b10:   ff_q[b] <= 1'b1;
                    2'b11:   ff_q[b] <= ~ff_q[b];
                    default: ff_q[b] <= ff_q[b];
                endcase
            end
        end
    end

    assign q_fb = ff_q ^ inj_val;

    // ---------------- checking helpers / reference model ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] v, input logic [1:0] op,
                                               input logic [W-1:0] m, input int cnt);
        case (op)
            OP_CLEAR:  return v & ~m;
            OP_SET:    return v | m;
            OP_TOGGLE: return (((cnt + 1) % 2) == 1) ? (v ^ m) : v;
            default:   return v;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(t < 200), 32'd1);
        clr_err = 1'b0;
        inj_val = '0;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] m, input int cnt,
                        input logic [W-1:0] inj, input logic clr);
        item_t it;
        bit    got = 0;
        if (inj != '0) wait_idle();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = m;
        cmd_count = cnt[3:0];
        inj_val   = inj;
        clr_err   = clr;
        for (int t = 0; t < 60; t++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(got), 32'd1);
        if (got) begin
            ref_v      = apply_cmd(ref_v, op, m, cnt);
            err_model  = (inj != '0) ? 1'b1 : (clr ? 1'b0 : err_model);
            it.op      = op;
            it.mask    = m;
            it.count   = cnt;
            it.exp_v   = ref_v;
            it.err_exp = err_model;
            it.acc_cyc = cyc + 1;
            last_acc   = cyc + 1;
            exp_q.push_back(it);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(3, 0));
        cmd_mask  = W'($urandom_range(15, 0));
        cmd_count = 4'($urandom_range(15, 0));
    endtask

    task automatic pulse_clr();
        wait_idle();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err   = 1'b0;
        err_model = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int           drive_cnt = 0;
    bit           pend = 0;
    logic         pend_err = 1'b0;
    item_t        mon_it;
    logic [W-1:0] j_exp, k_exp;

    always @(negedge clk) begin
        if (!reset) begin
            drive_cnt = 0;
            pend      = 0;
        end else begin
            if (pend) begin
                check("err_after_done", 32'(err), 32'(pend_err));
                pend = 0;
            end
            if (!busy) begin
                check("idle_outputs", 32'({j, k, cmd_ready, done}), 32'({W'(0), W'(0), 1'b1, 1'b0}));
            end else if (exp_q.size() == 0) begin
                check("busy_without_cmd", 32'd1, 32'd0);
            end else if (!done) begin
                drive_cnt++;
                mon_it = exp_q[0];
                j_exp  = (mon_it.op == OP_SET   || mon_it.op == OP_TOGGLE) ? mon_it.mask : '0;
                k_exp  = (mon_it.op == OP_CLEAR || mon_it.op == OP_TOGGLE) ? mon_it.mask : '0;
                check("drive_jk", 32'({j, k, cmd_ready}), 32'({j_exp, k_exp, 1'b0}));
            end else begin
                mon_it = exp_q.pop_front();
                check("check_jk_zero", 32'({j, k, cmd_ready}), 32'({W'(0), W'(0), 1'b0}));
                check("done_latency", 32'(cyc + 1 - mon_it.acc_cyc), 32'(mon_it.count + 2));
                check("drive_cycles", 32'(drive_cnt), 32'(mon_it.count + 1));
                check("flop_state", 32'(ff_q), 32'(mon_it.exp_v));
                pend      = 1;
                pend_err  = mon_it.err_exp;
                drive_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a, b, cnt;
        logic [1:0]   op;
        logic [W-1:0] m, inj;

        #1 reset = 1'b0;
        #1 check("reset_outputs", 32'({j, k, busy, done, err, cmd_ready}),
                 32'({W'(0), W'(0), 1'b0, 1'b0, 1'b0, 1'b1}));
        repeat (3) @(negedge clk);
        reset = 1'b1;

        send(OP_SET, 4'b0101, 0, '0, 1'b0);
        wait_idle();
        check("set_result", 32'(ff_q), 32'h5);

        send(OP_CLEAR, 4'b1111, 0, '0, 1'b0);
        send(OP_TOGGLE, 4'b1111, 2, '0, 1'b0);
        wait_idle();
        check("toggle_result", 32'(ff_q), 32'hf);

        send(OP_CLEAR, 4'b0001, 0, 4'b0001, 1'b0);
        wait_idle();
        send(OP_SET, 4'b0001, 1, '0, 1'b0);
        wait_idle();
        check("err_sticky", 32'(err), 32'd1);
        pulse_clr();

        send(OP_TOGGLE, 4'b0110, 0, 4'b1000, 1'b1);
        wait_idle();
        check("mismatch_beats_clear", 32'(err), 32'd1);
        pulse_clr();

        send(OP_SET, 4'b0011, 1, '0, 1'b0);
        a = last_acc;
        send(OP_CLEAR, 4'b0001, 0, '0, 1'b0);
        b = last_acc;
        check("b2b_spacing", 32'(b - a), 32'd4);

        send(OP_TOGGLE, 4'b0000, 3, '0, 1'b0);
        send(OP_HOLD, 4'b1111, 15, '0, 1'b0);
        wait_idle();

        send(OP_TOGGLE, 4'b1111, 15, '0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", 32'({j, k, busy, done, err, cmd_ready}),
                 32'({W'(0), W'(0), 1'b0, 1'b0, 1'b0, 1'b1}));
        exp_q.delete();
        ref_v     = '0;
        err_model = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(OP_SET, 4'b0001, 0, '0, 1'b0);
        wait_idle();
        check("post_reset_err", 32'(err), 32'd0);

        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom_range(3, 0));
            m   = W'($urandom_range(15, 0));
            cnt = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(4, 0));
            inj = ($urandom_range(5, 0) == 0) ? W'($urandom_range(15, 1)) : '0;
            send(op, m, cnt, inj, 1'b0);
            if (inj != '0 || $urandom_range(2, 0) == 0) wait_idle();
            if (err_model && $urandom_range(1, 0) == 1) pulse_clr();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
